// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_pkg
//  Purpose  : Shared types and constants for the matrix index sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  // Default width of every index and dimension
  localparam int MATRIX_IDX_W = 8;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Plain constants for code that prefers raw state values
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

endpackage : matrix_pkg
`default_nettype wire

// File: rtl/matrix_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_wrap_counter
//  Purpose  : Up-counter from 0 to limit that wraps to 0; wrap flags the top
//             value so counters can be chained (next.en = this.wrap & this.en).
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_wrap_counter #(
  parameter int IDX_W = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic [IDX_W-1:0] limit,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] count,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] c_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] c_ZERO = '0;

  logic [IDX_W-1:0] r_count;

  // Count up on enable, return to zero after reaching the limit or on clear
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_count <= c_ZERO;
    end else if (clr) begin
      r_count <= c_ZERO;
    end else if (en) begin
      if (wrap) begin
        r_count <= c_ZERO;
      end else begin
        r_count <= r_count + c_ONE;
      end
    end
  end

  assign wrap  = (r_count == limit);
  assign count = r_count;

endmodule : matrix_wrap_counter
`default_nettype wire

// File: rtl/matrix_index_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_index_sequencer
//  Purpose  : Generates the (i, j, k) index sweep of an MxK by KxN matrix
//             product in row-major order with k innermost, with stall support.
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_index_sequencer
  import matrix_pkg::*;
#(
  parameter int IDX_W   = MATRIX_IDX_W,
  parameter int MAX_DIM = 255
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic [IDX_W-1:0] a_rows,
  input  logic [IDX_W-1:0] a_cols,
  input  logic [IDX_W-1:0] b_cols,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             idx_valid,
  output logic             first_k,
  output logic             last_k,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [IDX_W-1:0] c_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] c_ZERO = '0;
  localparam logic [IDX_W-1:0] c_MAX  = MAX_DIM[IDX_W-1:0];

  seq_state_e       r_state;
  logic [IDX_W-1:0] r_m;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_n;
  logic             r_cfg_err;

  logic             w_run;
  logic             w_dims_ok;
  logic [IDX_W-1:0] w_m_lim;
  logic [IDX_W-1:0] w_k_lim;
  logic [IDX_W-1:0] w_n_lim;
  logic             w_clr;
  logic             w_k_en;
  logic             w_j_en;
  logic             w_i_en;
  logic             w_k_wrap;
  logic             w_j_wrap;
  logic             w_i_wrap;
  logic             w_last_beat;

  assign w_run = (r_state == RUN);

  // A dimension is legal when it lies in 1..MAX_DIM
  assign w_dims_ok = (a_rows != c_ZERO) && (a_rows <= c_MAX) &&
                     (a_cols != c_ZERO) && (a_cols <= c_MAX) &&
                     (b_cols != c_ZERO) && (b_cols <= c_MAX);

  // Counter limits are the last legal index of each loop
  assign w_m_lim = r_m - c_ONE;
  assign w_k_lim = r_k - c_ONE;
  assign w_n_lim = r_n - c_ONE;

  // Counters sit at zero whenever no sweep is running
  assign w_clr  = ~w_run;
  assign w_k_en = w_run & advance;
  assign w_j_en = w_k_en & w_k_wrap;
  assign w_i_en = w_j_en & w_j_wrap;

  // All three counters wrap together on the final accepted beat
  assign w_last_beat = w_i_en & w_i_wrap;

  matrix_wrap_counter #(.IDX_W(IDX_W)) u_k_cnt (
    .clock  (clock),
    .nreset (nreset),
    .limit  (w_k_lim),
    .en     (w_k_en),
    .clr    (w_clr),
    .count  (k),
    .wrap   (w_k_wrap)
  );

  matrix_wrap_counter #(.IDX_W(IDX_W)) u_j_cnt (
    .clock  (clock),
    .nreset (nreset),
    .limit  (w_n_lim),
    .en     (w_j_en),
    .clr    (w_clr),
    .count  (j),
    .wrap   (w_j_wrap)
  );

  matrix_wrap_counter #(.IDX_W(IDX_W)) u_i_cnt (
    .clock  (clock),
    .nreset (nreset),
    .limit  (w_m_lim),
    .en     (w_i_en),
    .clr    (w_clr),
    .count  (i),
    .wrap   (w_i_wrap)
  );

  // Sweep control: accept a legal start in IDLE, finish on the last beat
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && w_dims_ok) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_last_beat) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Dimension latch, written only by an accepted start
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_m <= c_ZERO;
      r_k <= c_ZERO;
      r_n <= c_ZERO;
    end else if ((r_state == IDLE) && start && w_dims_ok) begin
      r_m <= a_rows;
      r_k <= a_cols;
      r_n <= b_cols;
    end
  end

  // One-cycle error pulse for a start rejected in IDLE
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == IDLE) && start && !w_dims_ok;
    end
  end

  assign idx_valid = w_run;
  assign busy      = w_run;
  assign done      = (r_state == DONE);
  assign cfg_err   = r_cfg_err;
  assign first_k   = w_run & (k == c_ZERO);
  assign last_k    = w_run & (k == w_k_lim);

endmodule : matrix_index_sequencer
`default_nettype wire

// File: tb/tb_matrix_index_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_index_sequencer
//  Purpose  : Self-checking bench for matrix_index_sequencer; expected beats
//             come from nested loops over the requested dimensions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_index_sequencer;

  localparam int IDX_W   = 8;
  localparam int MAX_DIM = 200;

  logic             clock = 1'b0;
  logic             nreset = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] a_rows = '0;
  logic [IDX_W-1:0] a_cols = '0;
  logic [IDX_W-1:0] b_cols = '0;
  logic             advance = 1'b0;
  logic [IDX_W-1:0] dut_i;
  logic [IDX_W-1:0] dut_j;
  logic [IDX_W-1:0] dut_k;
  logic             dut_valid;
  logic             dut_first_k;
  logic             dut_last_k;
  logic             dut_busy;
  logic             dut_done;
  logic             dut_cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  matrix_index_sequencer #(.IDX_W(IDX_W), .MAX_DIM(MAX_DIM)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .start     (start),
    .a_rows    (a_rows),
    .a_cols    (a_cols),
    .b_cols    (b_cols),
    .advance   (advance),
    .i         (dut_i),
    .j         (dut_j),
    .k         (dut_k),
    .idx_valid (dut_valid),
    .first_k   (dut_first_k),
    .last_k    (dut_last_k),
    .busy      (dut_busy),
    .done      (dut_done),
    .cfg_err   (dut_cfg_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every output against the expected values
  task automatic check_all(input string tag, input int v, input int ii, input int jj,
                           input int kk, input int fk, input int lk, input int dn,
                           input int ce);
    chk({tag, ".valid"},   int'(dut_valid),   v);
    chk({tag, ".busy"},    int'(dut_busy),    v);
    chk({tag, ".i"},       int'(dut_i),       ii);
    chk({tag, ".j"},       int'(dut_j),       jj);
    chk({tag, ".k"},       int'(dut_k),       kk);
    chk({tag, ".first_k"}, int'(dut_first_k), fk);
    chk({tag, ".last_k"},  int'(dut_last_k),  lk);
    chk({tag, ".done"},    int'(dut_done),    dn);
    chk({tag, ".cfg_err"}, int'(dut_cfg_err), ce);
  endtask

  // Run one sweep. rnd: random stalls; stall_beat/stall_len: directed stall;
  // restart: hold start high with other dims during the sweep;
  // reset_at: beat number at which nreset is pulled low (-1 = never).
  task automatic sweep(input string name, input int m, input int kd, input int n,
                       input bit rnd, input int stall_beat, input int stall_len,
                       input bit restart, input int reset_at);
    int qi[$];
    int qj[$];
    int qk[$];
    int total;
    int pos;
    int cyc;
    int stalls;
    bit adv;
    for (int a = 0; a < m; a++)
      for (int b = 0; b < n; b++)
        for (int c = 0; c < kd; c++) begin
          qi.push_back(a);
          qj.push_back(b);
          qk.push_back(c);
        end
    total = m * n * kd;

    nreset  = 1'b1;
    start   = 1'b1;
    a_rows  = IDX_W'(m);
    a_cols  = IDX_W'(kd);
    b_cols  = IDX_W'(n);
    advance = 1'b0;
    @(negedge clock);
    if (restart) begin
      a_rows = IDX_W'(m % 4 + 2);
      a_cols = IDX_W'(kd % 4 + 2);
      b_cols = IDX_W'(n % 3 + 2);
    end else begin
      start = 1'b0;
    end

    pos = 0;
    cyc = 0;
    stalls = 0;
    while (pos < total && cyc < 5000) begin
      check_all($sformatf("%s.beat%0d", name, pos), 1, qi[pos], qj[pos], qk[pos],
                (qk[pos] == 0) ? 1 : 0, (qk[pos] == kd - 1) ? 1 : 0, 0, 0);
      if (pos == reset_at) begin
        nreset  = 1'b0;
        start   = 1'b0;
        advance = 1'b0;
        @(negedge clock);
        check_all({name, ".after_reset"}, 0, 0, 0, 0, 0, 0, 0, 0);
        return;
      end
      if (pos == stall_beat && stalls < stall_len) begin
        adv = 1'b0;
        stalls++;
      end else if (rnd) begin
        adv = ($urandom_range(0, 3) != 0);
      end else begin
        adv = 1'b1;
      end
      advance = adv;
      if (adv) pos++;
      @(negedge clock);
      cyc++;
    end
    chk({name, ".beats"}, pos, total);
    start   = 1'b0;
    advance = 1'b0;
    check_all({name, ".done"}, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clock);
    check_all({name, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int m, kd, n;

    // Reset state
    nreset = 1'b0;
    repeat (3) @(negedge clock);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic 2x3x2 sweep with continuous advance
    sweep("m2k3n2", 2, 3, 2, 1'b0, -1, 0, 1'b0, -1);

    // Three-cycle stall at beat (0,1,1)
    sweep("stall", 2, 2, 2, 1'b0, 3, 3, 1'b0, -1);

    // Single-beat sweep
    sweep("m1k1n1", 1, 1, 1, 1'b0, -1, 0, 1'b0, -1);

    // Rejected start: b_cols = 0
    start  = 1'b1;
    a_rows = 8'd2;
    a_cols = 8'd2;
    b_cols = 8'd0;
    @(negedge clock);
    start = 1'b0;
    check_all("cfg_zero", 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    check_all("cfg_zero_after", 0, 0, 0, 0, 0, 0, 0, 0);

    // Rejected start: dimension above MAX_DIM
    start  = 1'b1;
    a_rows = IDX_W'(MAX_DIM + 1);
    a_cols = 8'd1;
    b_cols = 8'd1;
    @(negedge clock);
    start = 1'b0;
    check_all("cfg_big", 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    check_all("cfg_big_after", 0, 0, 0, 0, 0, 0, 0, 0);

    // Largest legal inner dimension
    sweep("kmax", 1, MAX_DIM, 1, 1'b0, -1, 0, 1'b0, -1);

    // Reset during the sweep at (1,0,2), then a fresh single-beat sweep
    sweep("reset_mid", 2, 3, 2, 1'b0, -1, 0, 1'b0, 8);
    sweep("post_reset", 1, 1, 1, 1'b0, -1, 0, 1'b0, -1);

    // Start held high with other dimensions during the sweep
    sweep("restart", 2, 3, 2, 1'b1, -1, 0, 1'b1, -1);

    // Randomized dimensions and stalls
    for (int t = 0; t < 12; t++) begin
      m  = $urandom_range(1, 4);
      kd = $urandom_range(1, 4);
      n  = $urandom_range(1, 4);
      sweep($sformatf("rnd%0d", t), m, kd, n, 1'b1, -1, 0, t[0], -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_matrix_index_sequencer
`default_nettype wire
